// File: rtl/alu_seq.sv
// Word/long operation sequencer in front of a combinational WIDTH-bit ALU.
// Optional ALU_SEQ_STICKY_Z_EN: extended ops may only clear Z (multi-precision chains).
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               size,
    input  logic [2:0]         op,
    input  logic               ext,
    input  logic [2*WIDTH-1:0] src,
    input  logic [2*WIDTH-1:0] dst,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [4:0]         ccr,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_op,
    output logic               alu_x,
    input  logic [WIDTH-1:0]   alu_o,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               alu_v,
    input  logic               alu_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               size_q, size_d;
    logic [2:0]         op_q, op_d;
    logic               ext_q, ext_d;
    logic [2*WIDTH-1:0] src_q, src_d;
    logic [2*WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0]   o_lo_q, o_lo_d;
    logic               c_lo_q, c_lo_d;
    logic               z_lo_q, z_lo_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [4:0]         ccr_q, ccr_d;

    logic flag_upd, n_sel, z_sel, v_sel, c_sel, x_new, z_new;

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        op_d     = op_q;
        ext_d    = ext_q;
        src_d    = src_q;
        dst_d    = dst_q;
        o_lo_d   = o_lo_q;
        c_lo_d   = c_lo_q;
        z_lo_d   = z_lo_q;
        result_d = result_q;
        ccr_d    = ccr_q;
        busy     = 1'b0;
        done     = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = '0;
        alu_x    = 1'b0;
        flag_upd = 1'b0;
        n_sel    = 1'b0;
        z_sel    = 1'b0;
        v_sel    = 1'b0;
        c_sel    = 1'b0;
        x_new    = 1'b0;
        z_new    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    size_d  = size;
                    op_d    = op;
                    ext_d   = ext;
                    src_d   = src;
                    dst_d   = dst;
                    state_d = S_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                busy   = 1'b1;
                alu_a  = dst_q[WIDTH-1:0];
                alu_b  = src_q[WIDTH-1:0];
                alu_op = op_q;
                alu_x  = ext_q & ccr_q[4];
                o_lo_d = alu_o;
                c_lo_d = alu_c;
                z_lo_d = alu_z;
                if (size_q) begin
                    state_d = S_HI;
                end else begin
                    state_d  = S_DONE;
                    result_d = {dst_q[2*WIDTH-1:WIDTH], alu_o};
                    flag_upd = 1'b1;
                    n_sel    = alu_n;
                    z_sel    = alu_z;
                    v_sel    = alu_v;
                    c_sel    = alu_c;
                end
            end
            S_HI: begin
                busy     = 1'b1;
                alu_a    = dst_q[2*WIDTH-1:WIDTH];
                alu_b    = src_q[2*WIDTH-1:WIDTH];
                alu_op   = op_q;
                alu_x    = c_lo_q;
                state_d  = S_DONE;
                result_d = {alu_o, o_lo_q};
                flag_upd = 1'b1;
                n_sel    = alu_n;
                z_sel    = z_lo_q & alu_z;
                v_sel    = alu_v;
                c_sel    = alu_c;
            end
            default: state_d = S_IDLE;
        endcase

        // X tracks C only for add/sub; logical ops leave it alone.
        if (flag_upd) begin
            x_new = (op_q == 3'd0 || op_q == 3'd1) ? c_sel : ccr_q[4];
`ifdef ALU_SEQ_STICKY_Z_EN
            z_new = ext_q ? (ccr_q[2] & z_sel) : z_sel;
`else
            z_new = z_sel;
`endif
            ccr_d = {x_new, n_sel, z_new, v_sel, c_sel};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            size_q   <= 1'b0;
            op_q     <= '0;
            ext_q    <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            o_lo_q   <= '0;
            c_lo_q   <= 1'b0;
            z_lo_q   <= 1'b0;
            result_q <= '0;
            ccr_q    <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            op_q     <= op_d;
            ext_q    <= ext_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            o_lo_q   <= o_lo_d;
            c_lo_q   <= c_lo_d;
            z_lo_q   <= z_lo_d;
            result_q <= result_d;
            ccr_q    <= ccr_d;
        end
    end

    assign result = result_q;
    assign ccr    = ccr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, 32-bit reference model with per-cycle compare, directed vectors.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        size = 1'b0;
    logic [2:0]  op = '0;
    logic        ext = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  ccr;
    logic [15:0] alu_a, alu_b, alu_o;
    logic [2:0]  alu_op;
    logic        alu_x, alu_c, alu_z, alu_v, alu_n;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .op(op), .ext(ext),
        .src(src), .dst(dst), .busy(busy), .done(done), .result(result), .ccr(ccr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_x(alu_x),
        .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n)
    );

    function automatic logic [31:0] logic_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Combinational ALU: returns {c, v, z, n, o}
    function automatic logic [19:0] alu_f(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b, input logic x);
        logic [16:0] s;
        logic c, v;
        logic [31:0] lg;
        c = 1'b0;
        v = 1'b0;
        if (f == 3'd0) begin
            s = {1'b0, a} + {1'b0, b} + {16'b0, x};
            c = s[16];
            v = (a[15] == b[15]) && (s[15] != a[15]);
        end else if (f == 3'd1) begin
            s = {1'b0, a} - {1'b0, b} - {16'b0, x};
            c = s[16];
            v = (a[15] != b[15]) && (s[15] != a[15]);
        end else begin
            lg = logic_op(f, {16'b0, a}, {16'b0, b});
            s  = {1'b0, lg[15:0]};
        end
        return {c, v, (s[15:0] == 16'h0), s[15], s[15:0]};
    endfunction

    assign {alu_c, alu_v, alu_z, alu_n, alu_o} = alu_f(alu_op, alu_a, alu_b, alu_x);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: m_left = -1 idle, 0 in the done cycle, >0 busy cycles remaining.
    int          m_left = -1;
    logic [31:0] m_result = '0;
    logic [4:0]  m_ccr = '0;
    logic [31:0] p_result, p_src, p_dst;
    logic [4:0]  p_ccr;
    logic        p_size, p_xin, p_xhi;
    logic [2:0]  p_op;

    always @(posedge clk or posedge rst) begin
        logic [16:0] s17;
        logic [32:0] s33;
        logic [31:0] lg, r;
        logic        c, v, n, zc, z, x;
        if (rst) begin
            m_left   = -1;
            m_result = '0;
            m_ccr    = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_result = p_result;
                m_ccr    = p_ccr;
            end
        end else if (start) begin
            p_size = size; p_op = op; p_src = src; p_dst = dst;
            p_xin  = ext ? m_ccr[4] : 1'b0;
            p_xhi  = 1'b0;
            lg = logic_op(op, dst, src);
            if (!size) begin
                if (op == 3'd0)      s17 = {1'b0, dst[15:0]} + {1'b0, src[15:0]} + {16'b0, p_xin};
                else if (op == 3'd1) s17 = {1'b0, dst[15:0]} - {1'b0, src[15:0]} - {16'b0, p_xin};
                else                 s17 = {1'b0, lg[15:0]};
                r  = {dst[31:16], s17[15:0]};
                c  = (op <= 3'd1) ? s17[16] : 1'b0;
                n  = s17[15];
                zc = (s17[15:0] == 16'h0);
                v  = (op == 3'd0) ? (dst[15] == src[15] && s17[15] != dst[15]) :
                     (op == 3'd1) ? (dst[15] != src[15] && s17[15] != dst[15]) : 1'b0;
            end else begin
                if (op == 3'd0) begin
                    s33 = {1'b0, dst} + {1'b0, src} + {32'b0, p_xin};
                    s17 = {1'b0, dst[15:0]} + {1'b0, src[15:0]} + {16'b0, p_xin};
                    p_xhi = s17[16];
                end else if (op == 3'd1) begin
                    s33 = {1'b0, dst} - {1'b0, src} - {32'b0, p_xin};
                    s17 = {1'b0, dst[15:0]} - {1'b0, src[15:0]} - {16'b0, p_xin};
                    p_xhi = s17[16];
                end else begin
                    s33 = {1'b0, lg};
                end
                r  = s33[31:0];
                c  = (op <= 3'd1) ? s33[32] : 1'b0;
                n  = s33[31];
                zc = (s33[31:0] == 32'h0);
                v  = (op == 3'd0) ? (dst[31] == src[31] && s33[31] != dst[31]) :
                     (op == 3'd1) ? (dst[31] != src[31] && s33[31] != dst[31]) : 1'b0;
            end
`ifdef ALU_SEQ_STICKY_Z_EN
            z = ext ? (m_ccr[2] & zc) : zc;
`else
            z = zc;
`endif
            x = (op <= 3'd1) ? c : m_ccr[4];
            p_result = r;
            p_ccr    = {x, n, z, v, c};
            m_left   = size ? 2 : 1;
        end else begin
            m_left = -1;
        end
    end

    always @(negedge clk) begin
        logic in_lo, in_hi;
        in_lo = (m_left > 0) && ((p_size && m_left == 2) || (!p_size && m_left == 1));
        in_hi = (m_left == 1) && p_size;
        chk("busy", busy, m_left > 0);
        chk("done", done, m_left == 0);
        chk("result", result, m_result);
        chk("ccr", ccr, m_ccr);
        chk("alu_op", alu_op, (in_lo || in_hi) ? p_op : 3'd0);
        chk("alu_a", alu_a, in_lo ? p_dst[15:0] : in_hi ? p_dst[31:16] : 16'h0);
        chk("alu_b", alu_b, in_lo ? p_src[15:0] : in_hi ? p_src[31:16] : 16'h0);
        chk("alu_x", alu_x, in_lo ? p_xin : in_hi ? p_xhi : 1'b0);
    end

    task automatic set_in(input logic s, input logic [2:0] o, input logic e, input logic [31:0] d, input logic [31:0] sr);
        size = s; op = o; ext = e; dst = d; src = sr;
    endtask

    // Called just after the accepting edge; first negedge seen is cycle 1.
    task automatic wait_done(input int lat, input logic [31:0] er, input logic [4:0] ec, input string nm);
        int cnt;
        cnt = 0;
        for (int i = 1; i <= 8 && cnt == 0; i++) begin
            @(negedge clk);
            if (done) cnt = i;
        end
        chk({nm, " latency"}, cnt, lat);
        chk({nm, " result"}, result, er);
        chk({nm, " ccr"}, ccr, ec);
    endtask

    task automatic run_op(input logic s, input logic [2:0] o, input logic e, input logic [31:0] d,
                          input logic [31:0] sr, input logic [31:0] er, input logic [4:0] ec, input string nm);
        @(posedge clk); #2;
        set_in(s, o, e, d, sr);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(s ? 3 : 2, er, ec, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset result", result, 32'h0);
        chk("reset ccr", ccr, 5'h0);
        rst = 1'b0;

        run_op(1'b0, 3'd0, 1'b0, 32'h1234_7FFF, 32'h0000_0001, 32'h1234_8000, 5'b01010, "word add");
        run_op(1'b1, 3'd0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 5'b00000, "long carry");
        run_op(1'b1, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10101, "long wrap");
        run_op(1'b1, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010, "long ovf");
        run_op(1'b1, 3'd0, 1'b0, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 5'b10101, "long zlohi");
        run_op(1'b1, 3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 5'b00000, "ext x1");
`ifdef ALU_SEQ_STICKY_Z_EN
        run_op(1'b1, 3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 5'b00000, "ext sticky z");
`else
        run_op(1'b1, 3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 5'b00100, "ext plain z");
`endif

        // start pulsed in LO and HI with other operands must be ignored
        @(posedge clk); #2;
        set_in(1'b1, 3'd1, 1'b0, 32'h0000_0005, 32'h0000_0003);
        start = 1'b1;
        @(posedge clk); #2;
        set_in(1'b0, 3'd0, 1'b0, 32'hAAAA_AAAA, 32'h1111_1111);
        @(posedge clk); #2;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("ignore done", done, 1'b1);
        chk("ignore result", result, 32'h0000_0002);
        chk("ignore ccr", ccr, 5'b00000);

        // start held through DONE: second op accepted back-to-back
        @(posedge clk); #2;
        set_in(1'b0, 3'd2, 1'b0, 32'hFFFF_F0F0, 32'h0000_FF00);
        start = 1'b1;
        @(posedge clk); #2;
        set_in(1'b0, 3'd1, 1'b0, 32'h0000_0000, 32'h0000_0001);
        wait_done(2, 32'hFFFF_F000, 5'b01000, "b2b first");
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(2, 32'h0000_FFFF, 5'b11001, "b2b second");

        // asynchronous reset during HI
        @(posedge clk); #2;
        set_in(1'b1, 3'd0, 1'b0, 32'h1234_5678, 32'h1111_1111);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 32'h0);
        chk("abort ccr", ccr, 5'h0);
        chk("abort alu_a", alu_a, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no done", done, 1'b0);
        end
        run_op(1'b0, 3'd0, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 5'b00000, "after reset");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
